// File: rtl/cic_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module   : cic_decimator_mc
// Brief    : Multi-channel PDM CIC decimator, runtime ratio R = 2^k, with
//            normalised and saturated output. The optional out_sat port is
//            enabled by CIC_DECIMATOR_SAT_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cic_decimator_mc #(
    parameter int CHANNELS       = 2,
    parameter int ORDER          = 4,
    parameter int MAX_DECIM_LOG2 = 8,
    parameter int OUT_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           pdm_in,
    input  logic                          pdm_valid,
    input  logic [3:0]                    decim_log2,
    output logic [CHANNELS*OUT_WIDTH-1:0] out_data,
    output logic                          out_valid
`ifdef CIC_DECIMATOR_SAT_STATUS_EN
    ,
    output logic [CHANNELS-1:0]           out_sat
`endif
);

    localparam int c_W    = ORDER * MAX_DECIM_LOG2 + 2;
    localparam int c_NMAX = ORDER * MAX_DECIM_LOG2;
    localparam int c_RSH  = c_NMAX + 1 - OUT_WIDTH;
    localparam int c_NW   = OUT_WIDTH + 1;
    localparam int c_SHW  = $clog2(c_NMAX + 1);
    localparam int c_SCW  = $clog2(ORDER + 1);

    localparam logic                        c_ST_SETTLE = 1'b0;
    localparam logic                        c_ST_RUN    = 1'b1;
    localparam logic [c_W-1:0]              c_ONE       = c_W'(1);
    localparam logic [c_W-1:0]              c_MONE      = {c_W{1'b1}};
    localparam logic signed [OUT_WIDTH-1:0] c_OMAX      = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] c_OMIN      = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [3:0]                w_k_req;
    logic [3:0]                w_k_act;
    logic [3:0]                r_k;
    logic                      r_k_loaded;
    logic [MAX_DECIM_LOG2-1:0] r_cnt;
    logic [MAX_DECIM_LOG2-1:0] w_cnt_last;
    logic                      w_event;
    logic                      w_k_chg;
    logic                      w_pass;
    logic                      r_state;
    logic [c_SCW-1:0]          r_set_cnt;

    logic                      r_dec_vld;
    logic                      r_dec_pass;
    logic [3:0]                r_dec_k;
    logic [ORDER-1:0]          r_cvld;
    logic [ORDER-1:0]          r_cpass;
    logic [3:0]                r_ck [ORDER];
    logic                      r_out_vld;
    logic                      w_out_fire;
    logic [c_SHW-1:0]          w_lsh;

    always_comb begin
        w_k_req = decim_log2;
        if (decim_log2 == 4'd0)
            w_k_req = 4'd1;
        else if (int'(decim_log2) > MAX_DECIM_LOG2)
            w_k_req = 4'(MAX_DECIM_LOG2);
    end

    // Until the first post-reset edge the requested ratio is used directly.
    assign w_k_act = r_k_loaded ? r_k : w_k_req;

    always_comb begin
        w_cnt_last = '0;
        for (int i = 0; i < MAX_DECIM_LOG2; i++)
            w_cnt_last[i] = (i < int'(w_k_act));
    end

    assign w_event = pdm_valid && (r_cnt == w_cnt_last);
    assign w_k_chg = w_event && r_k_loaded && (w_k_req != r_k);
    // A frame that closes on a ratio change is itself the first suppressed output.
    assign w_pass  = w_event && !w_k_chg && (r_state == c_ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= 4'd1;
            r_k_loaded <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (!r_k_loaded || w_event)
                r_k <= w_k_req;
            r_k_loaded <= 1'b1;
            if (pdm_valid)
                r_cnt <= w_event ? '0 : r_cnt + MAX_DECIM_LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_SETTLE;
            r_set_cnt <= '0;
        end else if (w_event) begin
            if (w_k_chg) begin
                r_state   <= (ORDER <= 1) ? c_ST_RUN : c_ST_SETTLE;
                r_set_cnt <= c_SCW'(1);
            end else if (r_state == c_ST_SETTLE) begin
                if (r_set_cnt == c_SCW'(ORDER - 1))
                    r_state <= c_ST_RUN;
                r_set_cnt <= r_set_cnt + c_SCW'(1);
            end
        end
    end

    // Each result carries its own pass flag and ratio so later changes cannot touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_vld  <= 1'b0;
            r_dec_pass <= 1'b0;
            r_dec_k    <= 4'd1;
            r_cvld     <= '0;
            r_cpass    <= '0;
            for (int s = 0; s < ORDER; s++)
                r_ck[s] <= 4'd1;
            r_out_vld  <= 1'b0;
        end else begin
            r_dec_vld  <= w_event;
            r_dec_pass <= w_pass;
            if (w_event)
                r_dec_k <= w_k_act;
            r_cvld[0]  <= r_dec_vld;
            r_cpass[0] <= r_dec_pass;
            r_ck[0]    <= r_dec_k;
            for (int s = 1; s < ORDER; s++) begin
                r_cvld[s]  <= r_cvld[s-1];
                r_cpass[s] <= r_cpass[s-1];
                r_ck[s]    <= r_ck[s-1];
            end
            r_out_vld <= w_out_fire;
        end
    end

    assign w_out_fire = r_cvld[ORDER-1] && r_cpass[ORDER-1];
    assign w_lsh      = c_SHW'(c_NMAX - ORDER * int'(r_ck[ORDER-1]));
    assign out_valid  = r_out_vld;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [c_W-1:0]              r_int     [ORDER];
        logic [c_W-1:0]              w_int_nxt [ORDER];
        logic [c_W-1:0]              r_cdat    [ORDER];
        logic [c_W-1:0]              r_cdly    [ORDER];
        logic [c_W-1:0]              r_dec;
        logic signed [c_W-1:0]       w_shl;
        logic signed [c_NW-1:0]      w_nrm;
        logic                        w_clip;
        logic signed [OUT_WIDTH-1:0] w_sat;
        logic [OUT_WIDTH-1:0]        r_out;

        // Integrators are pipelined: each stage adds the previous stage's old value.
        always_comb begin
            w_int_nxt[0] = r_int[0] + (pdm_in[c] ? c_ONE : c_MONE);
            for (int s = 1; s < ORDER; s++)
                w_int_nxt[s] = r_int[s] + r_int[s-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < ORDER; s++) begin
                    r_int[s]  <= '0;
                    r_cdat[s] <= '0;
                    r_cdly[s] <= '0;
                end
                r_dec <= '0;
            end else begin
                if (pdm_valid)
                    for (int s = 0; s < ORDER; s++)
                        r_int[s] <= w_int_nxt[s];
                if (w_event)
                    r_dec <= w_int_nxt[ORDER-1];
                if (r_dec_vld) begin
                    r_cdat[0] <= r_dec - r_cdly[0];
                    r_cdly[0] <= r_dec;
                end
                for (int s = 1; s < ORDER; s++) begin
                    if (r_cvld[s-1]) begin
                        r_cdat[s] <= r_cdat[s-1] - r_cdly[s];
                        r_cdly[s] <= r_cdat[s-1];
                    end
                end
            end
        end

        // Scale every ratio up to the full-scale gain, then drop to the output width.
        assign w_shl  = $signed(r_cdat[ORDER-1]) <<< w_lsh;
        assign w_nrm  = c_NW'(w_shl >>> c_RSH);
        assign w_clip = w_nrm[OUT_WIDTH] ^ w_nrm[OUT_WIDTH-1];
        assign w_sat  = w_clip ? (w_nrm[OUT_WIDTH] ? c_OMIN : c_OMAX)
                               : w_nrm[OUT_WIDTH-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_out <= '0;
            else if (w_out_fire)
                r_out <= w_sat;
        end

        assign out_data[c*OUT_WIDTH +: OUT_WIDTH] = r_out;

`ifdef CIC_DECIMATOR_SAT_STATUS_EN
        logic w_rail;
        logic r_sat;

        // A sample pinned on either rail counts as clipped.
        assign w_rail = (w_sat == c_OMAX) || (w_sat == c_OMIN);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_sat <= 1'b0;
            else if (w_out_fire)
                r_sat <= w_rail;
        end

        assign out_sat[c] = r_sat;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_decimator_mc
// Brief    : Randomised self-checking bench for cic_decimator_mc against an
//            impulse-response (convolution) model of the CIC filter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_decimator_mc;

    localparam int CH   = 2;
    localparam int N    = 4;
    localparam int MAXK = 8;
    localparam int OW   = 16;
    localparam int HLEN = N * ((1 << MAXK) - 1) + 1;
    localparam int HMAX = 16384;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    pdm_in = '0;
    logic             pdm_valid = 1'b0;
    logic [3:0]       decim_log2 = 4'd3;
    logic [CH*OW-1:0] out_data;
    logic             out_valid;
`ifdef CIC_DECIMATOR_SAT_STATUS_EN
    logic [CH-1:0]    out_sat;
`endif

    cic_decimator_mc #(
        .CHANNELS(CH), .ORDER(N), .MAX_DECIM_LOG2(MAXK), .OUT_WIDTH(OW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pdm_in     (pdm_in),
        .pdm_valid  (pdm_valid),
        .decim_log2 (decim_log2),
        .out_data   (out_data),
        .out_valid  (out_valid)
`ifdef CIC_DECIMATOR_SAT_STATUS_EN
        ,
        .out_sat    (out_sat)
`endif
    );

    always #5 clk = ~clk;

    int     n_total = 0;
    int     n_bad   = 0;
    int     cyc     = 0;

    longint h_tab [MAXK+1][HLEN];
    longint h_a [HLEN];
    longint h_b [HLEN];
    int     hist [CH][HMAX];
    int     n_acc;
    int     m_fcnt;
    int     m_k;
    int     m_supp;
    bit     m_loaded;
    int     exp_cyc [$];
    longint exp_d [$];
    longint last_d [CH];
    logic [CH-1:0] exp_s [$];
    logic [CH-1:0] last_s;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int kclamp(input int v);
        if (v == 0) return 1;
        if (v > MAXK) return MAXK;
        return v;
    endfunction

    // Coefficients of (1 + z^-1 + ... + z^-(R-1))^N for every supported ratio.
    task automatic build_h();
        for (int k = 1; k <= MAXK; k++) begin
            int r = 1 << k;
            int len = 1;
            for (int i = 0; i < HLEN; i++) h_a[i] = 0;
            h_a[0] = 1;
            for (int st = 0; st < N; st++) begin
                for (int i = 0; i < HLEN; i++) h_b[i] = 0;
                for (int i = 0; i < len; i++)
                    for (int j = 0; j < r; j++)
                        h_b[i+j] += h_a[i];
                len += r - 1;
                for (int i = 0; i < HLEN; i++) h_a[i] = h_b[i];
            end
            for (int i = 0; i < HLEN; i++) h_tab[k][i] = h_a[i];
        end
    endtask

    // Filter output for the sample just appended; pipelined integrators add N-1 samples of delay.
    function automatic longint model_out(input int c, input int k);
        longint acc = 0;
        int hl = N * ((1 << k) - 1) + 1;
        for (int j = 0; j < hl; j++) begin
            int idx = n_acc - 1 - (N - 1) - j;
            if (idx >= 0) acc += h_tab[k][j] * longint'(hist[c][idx]);
        end
        acc = acc <<< (N * (MAXK - k));
        acc = acc >>> (N * MAXK + 1 - OW);
        if (acc > longint'(32767)) acc = 32767;
        if (acc < longint'(-32768)) acc = -32768;
        return acc;
    endfunction

    task automatic model_clear();
        n_acc = 0; m_fcnt = 0; m_supp = N; m_loaded = 0; m_k = 1;
        exp_cyc.delete(); exp_d.delete(); exp_s.delete();
        for (int c = 0; c < CH; c++) last_d[c] = 0;
        last_s = '0;
    endtask

    task automatic model_edge();
        int  kreq;
        bit  pass;
        logic [CH-1:0] sflags;
        cyc++;
        if (!rst_n) return;
        kreq = kclamp(int'(decim_log2));
        if (!m_loaded) begin
            m_k = kreq;
            m_loaded = 1;
        end
        if (!pdm_valid) return;
        if (n_acc < HMAX) begin
            for (int c = 0; c < CH; c++) hist[c][n_acc] = pdm_in[c] ? 1 : -1;
            n_acc++;
        end
        m_fcnt++;
        if (m_fcnt == (1 << m_k)) begin
            m_fcnt = 0;
            if (kreq != m_k) begin
                pass = 0;
                m_supp = N - 1;
            end else if (m_supp > 0) begin
                pass = 0;
                m_supp--;
            end else begin
                pass = 1;
            end
            if (pass) begin
                exp_cyc.push_back(cyc + N + 1);
                for (int c = 0; c < CH; c++) begin
                    longint v = model_out(c, m_k);
                    exp_d.push_back(v);
                    sflags[c] = (v == 32767) || (v == -32768);
                end
                exp_s.push_back(sflags);
            end
            m_k = kreq;
        end
    endtask

    task automatic check_outputs();
        if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
            check_val("strobe", longint'(out_valid), 1);
            void'(exp_cyc.pop_front());
            for (int c = 0; c < CH; c++) last_d[c] = exp_d.pop_front();
            last_s = exp_s.pop_front();
        end else begin
            check_val("idle", longint'(out_valid), 0);
        end
        for (int c = 0; c < CH; c++)
            check_val($sformatf("data_ch%0d", c),
                      longint'($signed(out_data[c*OW +: OW])), last_d[c]);
`ifdef CIC_DECIMATOR_SAT_STATUS_EN
        check_val("sat", longint'(out_sat), longint'(last_s));
`endif
    endtask

    task automatic step(input logic v, input logic [CH-1:0] d);
        pdm_valid = v;
        pdm_in    = d;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_rand(input int cycles, input int valid_pct);
        for (int i = 0; i < cycles; i++)
            step(($urandom_range(99) < valid_pct), CH'($urandom));
    endtask

    initial begin
        build_h();
        model_clear();

        // Reset state
        rst_n = 1'b0;
        #1;
        check_val("rst_valid", longint'(out_valid), 0);
        check_val("rst_data", longint'(out_data), 0);
        for (int i = 0; i < 3; i++) step(1'b1, '1);
        rst_n = 1'b1;

        // Full-scale inputs at k=3: ch0 rails high, ch1 rails low
        decim_log2 = 4'd3;
        for (int i = 0; i < 100; i++) step(1'b1, 2'b01);
        check_val("fs_ch0", longint'($signed(out_data[0 +: OW])), 32767);
        check_val("fs_ch1", longint'($signed(out_data[OW +: OW])), -32768);
`ifdef CIC_DECIMATOR_SAT_STATUS_EN
        check_val("fs_sat", longint'(out_sat), 3);
`endif

        // Alternating input at k=4 averages to zero
        decim_log2 = 4'd4;
        for (int i = 0; i < 150; i++) step(1'b1, (i % 2 == 0) ? 2'b11 : 2'b00);
        check_val("alt_ch0", longint'($signed(out_data[0 +: OW])), 0);
        check_val("alt_ch1", longint'($signed(out_data[OW +: OW])), 0);

        // k=2 with pdm_valid on every third cycle
        decim_log2 = 4'd2;
        for (int i = 0; i < 150; i++) step((i % 3) == 0, CH'($urandom));

        // Ratio change 3 -> 5 in the middle of a frame
        decim_log2 = 4'd3;
        run_rand(53, 100);
        decim_log2 = 4'd5;
        run_rand(300, 100);

        // Clamped ratio indices
        decim_log2 = 4'd0;
        run_rand(60, 100);
        decim_log2 = 4'd15;
        run_rand(1600, 100);

        // Reset asserted in the middle of a frame
        decim_log2 = 4'd3;
        run_rand(45, 100);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_val("midrst_valid", longint'(out_valid), 0);
        check_val("midrst_data", longint'(out_data), 0);
        run_rand(3, 100);
        rst_n = 1'b1;
        run_rand(80, 100);

        // Random traffic with occasional ratio changes
        for (int blk = 0; blk < 6; blk++) begin
            decim_log2 = 4'($urandom_range(5));
            run_rand(250, 70);
        end

        // Drain in-flight results
        for (int i = 0; i < 20; i++) step(1'b0, '0);
        check_val("drain", longint'(exp_cyc.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
